fwd_scoreboard: RTL and testbench
=================================

Name: fwd_scoreboard

Overview:
- Parametrised successor to the pipeline's two-source, two-stage forwarding logic.
- Tracks every in-flight register write across NUM_STAGES post-EX stages, including producers with multi-cycle result latency (loads, multi-cycle ALU ops).
- For each of NUM_SRC source operands in EX, generates a bypass select; raises a load-use/latency stall when the youngest matching producer's result is not yet available.
- Sits between the EX-stage decode fields and the EX operand muxes and hazard/stall logic. Keeps a saturating stall-cycle performance counter.

Parameters:
- NUM_STAGES, 3, number of tracked stages after EX; stage 0 = MEM, stage NUM_STAGES-1 = WB.
- NUM_SRC, 2, number of source operands checked per EX instruction.
- LAT_W, 2, width of the producer latency field.
- CNT_W, 32, width of the stall-cycle counter.
- SEL_W, $clog2(NUM_STAGES+1), derived (localparam), width of each bypass select.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, asynchronous, active-high reset.
- ex_valid, input, 1, EX holds a real instruction.
- ex_rs, input, NUM_SRC*5, source register indices; source s occupies bits [5s+4:5s].
- ex_rs_used, input, NUM_SRC, source s is actually read by the instruction.
- ex_rd, input, 5, destination register of the EX instruction.
- ex_reg_write, input, 1, EX instruction writes ex_rd.
- ex_lat, input, LAT_W, extra cycles after entering MEM before the result exists (0 = ALU, 1 = load).
- flush, input, 1, kill the EX instruction this cycle.
- fwd_sel, output, NUM_SRC*SEL_W, per-source select: 0 = register file, k = stage k-1.
- stall, output, 1, hold IF/ID/EX and inject a bubble into MEM.
- stall_cycles, output, CNT_W, saturating count of stalled cycles.
- lat_err, output, 1, sticky flag: ex_lat was out of range.

Behaviour:
- **State.** Entry[k] for k = 0..NUM_STAGES-1 holds {v, rd[4:0], cnt[LAT_W-1:0]}. An entry is ready when cnt == 0.
- **Reset (async, rst=1).**
  - All v=0, cnt=0, stall_cycles=0, lat_err=0.
  - Outputs then read fwd_sel all 0 and stall=0.
  - Reset mid-stall releases stall immediately (combinational path from cleared state).
- **Shift, every cycle.** Downstream stages never stall.
  - Entry[k] <= Entry[k-1] for k >= 1, with cnt decremented and saturating at 0.
  - The entry leaving the last stage retires. The register file is write-first, so no stage beyond WB is needed.
- **Capture into Entry[0].**
  - If ex_valid && !stall && !flush: v = ex_reg_write && (ex_rd != 0), rd = ex_rd, cnt = ex_lat.
  - Otherwise Entry[0] gets a bubble (v=0).
- **Latency clamp.** If ex_lat > NUM_STAGES-1 on a capture, cnt = NUM_STAGES-1 and lat_err is set to 1. lat_err stays set until rst.
- **Select (combinational from state and EX inputs), per source s:**
  - If !ex_valid, !ex_rs_used[s], or ex_rs[s] == 0: sel = 0 and no stall contribution.
  - Otherwise scan k = 0 upward. The first (youngest) entry with v && rd == ex_rs[s] gives sel = k+1; older matches are ignored.
  - No match gives sel = 0.
- **Stall.**
  - raw_stall = OR over sources of (a youngest match exists && its cnt != 0).
  - stall = raw_stall && !flush. When flush is high, the flush wins and the bubble is inserted anyway.
  - While stalled, fwd_sel still shows the youngest match's stage index. Consumers ignore it until stall drops.
- **stall_cycles.** Increments by 1 on each edge where stall = 1; holds at all-ones (saturates).
- **Timing.**
  - An ALU producer (lat 0) is forwardable from stage 0 on the very next cycle, so back-to-back dependents see no stall.
  - A load (lat 1) followed by a dependent stalls exactly 1 cycle; the dependent then sees sel = 2.
  - In general, a latency-L producer with an immediate dependent costs L stall cycles.
- **Simultaneous events.**
  - A producer writing x0 never creates an entry.
  - Two in-flight writes to the same rd: the younger one is always selected, even if not ready (stall), never the older ready one.
  - Both sources matching different stages is legal; stall if either is unready.

Test Plan:
- Reset, then ALU `x5 <= ...` (lat 0) followed next cycle by `add x6, x5, x5` → fwd_sel = {1,1}, stall=0; one cycle later an unrelated reader of x5 gets sel = 2.
- Load `x7` (lat 1), then dependent reading x7 as rs2 → stall=1 for exactly 1 cycle, stall_cycles = 1; next cycle sel(rs2) = 2, stall=0.
- Producer writing x0 with lat 2, then a reader of x0 → sel = 0, stall never asserted, no entry captured.
- Load x9 (lat 1) in stage 1 with ALU x9 (lat 0) in stage 0 → sel = 1 (the younger producer); then repeat with the younger x9 at lat 1 unready → stall=1 despite the ready older producer.
- ex_lat = 3 with NUM_STAGES = 3 → lat_err = 1 and sticky; the entry becomes ready in stage 2; assert rst mid-stall → stall=0, fwd_sel=0, counters cleared within the same cycle.
- flush asserted during a would-be stall → stall=0, Entry[0] bubble, stall_cycles unchanged.

Source files
------------

// File: rtl/fwd_if.sv
// EX-stage decode fields into the forwarding scoreboard, and the bypass/stall results back out.
interface fwd_if #(
    parameter int NUM_SRC = 2,
    parameter int LAT_W   = 2,
    parameter int CNT_W   = 32,
    parameter int SEL_W   = 2
);
    logic                     ex_valid;
    logic [NUM_SRC*5-1:0]     ex_rs;
    logic [NUM_SRC-1:0]       ex_rs_used;
    logic [4:0]               ex_rd;
    logic                     ex_reg_write;
    logic [LAT_W-1:0]         ex_lat;
    logic                     flush;
    logic [NUM_SRC*SEL_W-1:0] fwd_sel;
    logic                     stall;
    logic [CNT_W-1:0]         stall_cycles;
    logic                     lat_err;

    modport master (
        output ex_valid, ex_rs, ex_rs_used, ex_rd, ex_reg_write, ex_lat, flush,
        input  fwd_sel, stall, stall_cycles, lat_err
    );

    modport slave (
        input  ex_valid, ex_rs, ex_rs_used, ex_rd, ex_reg_write, ex_lat, flush,
        output fwd_sel, stall, stall_cycles, lat_err
    );
endinterface

// File: rtl/fwd_scoreboard.sv
// Tracks in-flight register writes across the post-EX stages and produces per-source
// bypass selects plus a latency stall for producers whose result is not yet available.
module fwd_scoreboard #(
    parameter int NUM_STAGES = 3,
    parameter int NUM_SRC    = 2,
    parameter int LAT_W      = 2,
    parameter int CNT_W      = 32
) (
    input  logic  clk,
    input  logic  rst,
    fwd_if.slave  bus
);
    localparam int SEL_W   = $clog2(NUM_STAGES + 1);
    localparam int LAT_MAX = NUM_STAGES - 1;

    logic [NUM_STAGES-1:0] v_q, v_d;
    logic [4:0]            rd_q  [NUM_STAGES];
    logic [4:0]            rd_d  [NUM_STAGES];
    logic [LAT_W-1:0]      cnt_q [NUM_STAGES];
    logic [LAT_W-1:0]      cnt_d [NUM_STAGES];
    logic [CNT_W-1:0]      stall_cycles_q, stall_cycles_d;
    logic                  lat_err_q, lat_err_d;

    logic [NUM_SRC*SEL_W-1:0] fwd_sel;
    logic [NUM_SRC-1:0]       hit;
    logic                     raw_stall;
    logic                     stall;
    logic                     capture;
    logic                     lat_over;

    // Youngest matching entry wins, even if an older one is already ready.
    always_comb begin
        fwd_sel   = '0;
        hit       = '0;
        raw_stall = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (bus.ex_valid && bus.ex_rs_used[s] && (bus.ex_rs[5*s +: 5] != 5'd0)) begin
                for (int k = 0; k < NUM_STAGES; k++) begin
                    if (!hit[s] && v_q[k] && (rd_q[k] == bus.ex_rs[5*s +: 5])) begin
                        hit[s]                    = 1'b1;
                        fwd_sel[s*SEL_W +: SEL_W] = SEL_W'(k + 1);
                        if (cnt_q[k] != '0) begin
                            raw_stall = 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign stall    = raw_stall && !bus.flush;
    assign capture  = bus.ex_valid && !stall && !bus.flush;
    assign lat_over = int'(bus.ex_lat) > LAT_MAX;

    always_comb begin
        v_d[0]   = capture && bus.ex_reg_write && (bus.ex_rd != 5'd0);
        rd_d[0]  = bus.ex_rd;
        cnt_d[0] = lat_over ? LAT_W'(LAT_MAX) : bus.ex_lat;
        for (int k = 1; k < NUM_STAGES; k++) begin
            v_d[k]   = v_q[k-1];
            rd_d[k]  = rd_q[k-1];
            cnt_d[k] = (cnt_q[k-1] == '0) ? '0 : cnt_q[k-1] - LAT_W'(1);
        end
        lat_err_d      = lat_err_q || (capture && lat_over);
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q            <= '0;
            stall_cycles_q <= '0;
            lat_err_q      <= 1'b0;
            for (int k = 0; k < NUM_STAGES; k++) begin
                rd_q[k]  <= '0;
                cnt_q[k] <= '0;
            end
        end else begin
            v_q            <= v_d;
            stall_cycles_q <= stall_cycles_d;
            lat_err_q      <= lat_err_d;
            for (int k = 0; k < NUM_STAGES; k++) begin
                rd_q[k]  <= rd_d[k];
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign bus.fwd_sel      = fwd_sel;
    assign bus.stall        = stall;
    assign bus.stall_cycles = stall_cycles_q;
    assign bus.lat_err      = lat_err_q;
endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: an issue-time model of in-flight producers is checked
// against the DUT every cycle, alongside hand-computed expectations at key points.
module tb_fwd_scoreboard;
    localparam int NS    = 3;
    localparam int NSRC  = 2;
    localparam int LW    = 2;
    localparam int CW    = 32;
    localparam int SW    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fwd_if #(.NUM_SRC(NSRC), .LAT_W(LW), .CNT_W(CW), .SEL_W(SW)) bus ();

    fwd_scoreboard #(.NUM_STAGES(NS), .NUM_SRC(NSRC), .LAT_W(LW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: each captured producer remembers the cycle it enters MEM; its stage is
    // simply (now - issue), and it is ready once that stage reaches its latency.
    int op_issue[$];
    int op_rd[$];
    int op_lat[$];
    int cyc;
    int exp_cnt;
    logic exp_lat_err;

    function automatic void model_eval(output logic [NSRC*SW-1:0] sel, output logic st);
        logic raw;
        raw = 1'b0;
        sel = '0;
        for (int s = 0; s < NSRC; s++) begin
            int best;
            int bstage;
            int rs;
            best   = -1;
            bstage = NS;
            rs     = int'(bus.ex_rs[5*s +: 5]);
            if (bus.ex_valid && bus.ex_rs_used[s] && rs != 0) begin
                for (int i = 0; i < op_issue.size(); i++) begin
                    int stage;
                    stage = cyc - op_issue[i];
                    if (stage >= 0 && stage < NS && op_rd[i] == rs && stage < bstage) begin
                        best   = i;
                        bstage = stage;
                    end
                end
            end
            if (best >= 0) begin
                sel[s*SW +: SW] = SW'(bstage + 1);
                if (bstage < op_lat[best]) raw = 1'b1;
            end
        end
        st = raw && !bus.flush;
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [NSRC*SW-1:0] s_m;
        logic st_m;
        logic cap;
        if (rst) begin
            op_issue.delete();
            op_rd.delete();
            op_lat.delete();
            cyc         = 0;
            exp_cnt     = 0;
            exp_lat_err = 1'b0;
        end else begin
            model_eval(s_m, st_m);
            cap = bus.ex_valid && !st_m && !bus.flush;
            if (cap && int'(bus.ex_lat) > NS - 1) exp_lat_err = 1'b1;
            if (cap && bus.ex_reg_write && bus.ex_rd != 5'd0) begin
                op_issue.push_back(cyc + 1);
                op_rd.push_back(int'(bus.ex_rd));
                op_lat.push_back(int'(bus.ex_lat) > NS - 1 ? NS - 1 : int'(bus.ex_lat));
            end
            if (st_m) exp_cnt++;
            cyc++;
        end
    end

    always @(negedge clk) begin
        logic [NSRC*SW-1:0] s_m;
        logic st_m;
        if (!rst) begin
            model_eval(s_m, st_m);
            chk("model_fwd_sel", 64'(bus.fwd_sel), 64'(s_m));
            chk("model_stall", 64'(bus.stall), 64'(st_m));
            chk("model_stall_cycles", 64'(bus.stall_cycles), 64'(exp_cnt));
            chk("model_lat_err", 64'(bus.lat_err), 64'(exp_lat_err));
        end
    end

    task automatic step(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [1:0] used, input logic [4:0] rd, input logic wr,
                        input logic [1:0] lat, input logic fl);
        @(posedge clk);
        #1;
        bus.ex_valid     = v;
        bus.ex_rs        = {r2, r1};
        bus.ex_rs_used   = used;
        bus.ex_rd        = rd;
        bus.ex_reg_write = wr;
        bus.ex_lat       = lat;
        bus.flush        = fl;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 2'd0, 1'b0);
    endtask

    initial begin
        bus.ex_valid     = 1'b0;
        bus.ex_rs        = '0;
        bus.ex_rs_used   = '0;
        bus.ex_rd        = '0;
        bus.ex_reg_write = 1'b0;
        bus.ex_lat       = '0;
        bus.flush        = 1'b0;
        #2;
        chk("reset_fwd_sel", 64'(bus.fwd_sel), 64'd0);
        chk("reset_stall", 64'(bus.stall), 64'd0);
        chk("reset_stall_cycles", 64'(bus.stall_cycles), 64'd0);
        chk("reset_lat_err", 64'(bus.lat_err), 64'd0);
        #10;
        rst = 1'b0;

        // ALU x5 then back-to-back dependent, then older reader
        step(1'b1, 5'd1, 5'd2, 2'b00, 5'd5, 1'b1, 2'd0, 1'b0);
        step(1'b1, 5'd5, 5'd5, 2'b11, 5'd6, 1'b1, 2'd0, 1'b0);
        chk("alu_b2b_sel", 64'(bus.fwd_sel), 64'h5);
        chk("alu_b2b_stall", 64'(bus.stall), 64'd0);
        step(1'b1, 5'd5, 5'd0, 2'b01, 5'd0, 1'b0, 2'd0, 1'b0);
        chk("alu_stage1_sel", 64'(bus.fwd_sel), 64'h2);
        idle(3);

        // load-use: one stall cycle, then forward from stage 1
        step(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 2'd1, 1'b0);
        step(1'b1, 5'd3, 5'd7, 2'b10, 5'd8, 1'b1, 2'd0, 1'b0);
        chk("load_use_stall", 64'(bus.stall), 64'd1);
        chk("load_use_sel_stalled", 64'(bus.fwd_sel), 64'h4);
        step(1'b1, 5'd3, 5'd7, 2'b10, 5'd8, 1'b1, 2'd0, 1'b0);
        chk("load_use_release", 64'(bus.stall), 64'd0);
        chk("load_use_sel", 64'(bus.fwd_sel), 64'h8);
        chk("load_use_count", 64'(bus.stall_cycles), 64'd1);
        idle(3);

        // writes to x0 never create entries
        step(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 2'd2, 1'b0);
        step(1'b1, 5'd0, 5'd0, 2'b01, 5'd4, 1'b1, 2'd0, 1'b0);
        chk("x0_sel", 64'(bus.fwd_sel), 64'd0);
        chk("x0_stall", 64'(bus.stall), 64'd0);
        idle(3);

        // younger ready producer beats older
        step(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 2'd1, 1'b0);
        step(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 2'd0, 1'b0);
        step(1'b1, 5'd9, 5'd0, 2'b01, 5'd0, 1'b0, 2'd0, 1'b0);
        chk("younger_ready_sel", 64'(bus.fwd_sel), 64'h1);
        chk("younger_ready_stall", 64'(bus.stall), 64'd0);
        idle(3);

        // younger unready producer stalls despite ready older one
        step(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 2'd0, 1'b0);
        step(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 2'd1, 1'b0);
        step(1'b1, 5'd9, 5'd0, 2'b01, 5'd0, 1'b0, 2'd0, 1'b0);
        chk("younger_unready_stall", 64'(bus.stall), 64'd1);
        chk("younger_unready_sel", 64'(bus.fwd_sel), 64'h1);
        step(1'b1, 5'd9, 5'd0, 2'b01, 5'd0, 1'b0, 2'd0, 1'b0);
        chk("younger_later_sel", 64'(bus.fwd_sel), 64'h2);
        chk("younger_count", 64'(bus.stall_cycles), 64'd2);
        idle(3);

        // latency clamp: lat 3 -> ready only in stage 2
        step(1'b1, 5'd0, 5'd0, 2'b00, 5'd10, 1'b1, 2'd3, 1'b0);
        step(1'b1, 5'd10, 5'd0, 2'b01, 5'd0, 1'b0, 2'd0, 1'b0);
        chk("clamp_lat_err", 64'(bus.lat_err), 64'd1);
        chk("clamp_stall_s0", 64'(bus.stall), 64'd1);
        step(1'b1, 5'd10, 5'd0, 2'b01, 5'd0, 1'b0, 2'd0, 1'b0);
        chk("clamp_stall_s1", 64'(bus.stall), 64'd1);
        chk("clamp_sel_s1", 64'(bus.fwd_sel), 64'h2);
        step(1'b1, 5'd10, 5'd0, 2'b01, 5'd0, 1'b0, 2'd0, 1'b0);
        chk("clamp_ready_s2", 64'(bus.stall), 64'd0);
        chk("clamp_sel_s2", 64'(bus.fwd_sel), 64'h3);
        chk("clamp_count", 64'(bus.stall_cycles), 64'd4);
        chk("clamp_lat_err_sticky", 64'(bus.lat_err), 64'd1);

        // async reset in the middle of a stall
        step(1'b1, 5'd0, 5'd0, 2'b00, 5'd11, 1'b1, 2'd1, 1'b0);
        step(1'b1, 5'd0, 5'd11, 2'b10, 5'd0, 1'b0, 2'd0, 1'b0);
        chk("pre_reset_stall", 64'(bus.stall), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_stall", 64'(bus.stall), 64'd0);
        chk("midrst_sel", 64'(bus.fwd_sel), 64'd0);
        chk("midrst_count", 64'(bus.stall_cycles), 64'd0);
        chk("midrst_lat_err", 64'(bus.lat_err), 64'd0);
        bus.ex_valid = 1'b0;
        #2;
        rst = 1'b0;

        // flush overrides stall; flushed instruction leaves a bubble
        step(1'b1, 5'd0, 5'd0, 2'b00, 5'd12, 1'b1, 2'd1, 1'b0);
        step(1'b1, 5'd12, 5'd0, 2'b01, 5'd13, 1'b1, 2'd0, 1'b1);
        chk("flush_stall", 64'(bus.stall), 64'd0);
        chk("flush_sel", 64'(bus.fwd_sel), 64'h1);
        step(1'b1, 5'd12, 5'd13, 2'b11, 5'd0, 1'b0, 2'd0, 1'b0);
        chk("flush_bubble_sel", 64'(bus.fwd_sel), 64'h2);
        chk("flush_count", 64'(bus.stall_cycles), 64'd0);
        idle(4);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
